hd44780_responder: RTL and testbench

//  Display-side end of the 8-bit HD44780/WEH001602 parallel bus: samples RS, R/W, E, DB

---
 rtl/hd44780_pkg.sv | 38 +++
 rtl/hd44780_responder_ddram.sv | 24 ++
 rtl/hd44780_responder.sv | 174 +++++++++++++++++
 tb/tb_hd44780_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780-style character display responder:
// instruction masks, DDRAM geometry, FSM states and address-counter helpers.
package hd44780_pkg;

  localparam int LINE_W      = 1;
  localparam int COL_W       = 4;
  localparam int ADDR_W      = LINE_W + COL_W;
  localparam int DDRAM_DEPTH = 32;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Instruction masks; the highest set bit of an RS=0 write selects the instruction.
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_BUSY  = 2'd3
  } state_t;

  // AC is {line, col}; plain modulo-32 stepping gives the line wrap in both directions.
  function automatic logic [ADDR_W-1:0] ac_step(input logic [ADDR_W-1:0] ac, input logic inc);
    return inc ? ac + ADDR_W'(1) : ac - ADDR_W'(1);
  endfunction

  function automatic logic [7:0] status_byte(input logic busy, input logic [ADDR_W-1:0] ac);
    return {busy, ac[ADDR_W-1], 2'b00, ac[COL_W-1:0]};
  endfunction

endpackage

// File: rtl/hd44780_responder_ddram.sv
// 2x16 display data RAM: one synchronous write port and two registered read ports
// (bus read and host view); a same-cycle read of a written address returns the old byte.
module ddram_2x16
  import hd44780_pkg::*;
(
  input  logic              clk_48mhz,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [7:0]        rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [7:0]        rdata_b
);

  logic [7:0] mem [DDRAM_DEPTH];

  always_ff @(posedge clk_48mhz) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/hd44780_responder.sv
// Display-side model of the 8-bit HD44780 parallel bus: synchronizes the master's
// pins, decodes instructions, owns DDRAM, address counter and busy flag, answers reads.
module hd44780_responder
  import hd44780_pkg::*;
#(
  parameter int BUSY_CYCLES  = 48,
  parameter int CLEAR_CYCLES = 4800
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       rs_pin,
  input  logic       rw_pin,
  input  logic       e_pin,
  input  logic [7:0] db_in,
  output logic [7:0] db_out,
  output logic       db_oe,
  output logic       busy,
  output logic       display_on,
  output logic       cmd_valid,
  output logic [8:0] cmd_word,
  output logic       proto_err,
  input  logic [4:0] view_addr,
  output logic [7:0] view_data
);

  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DDRAM_DEPTH - 1);

  // Bus protocol: the master sets RS, R/W and DB, raises E, then drops E while they
  // stay stable; the falling edge of the synchronized E is the single commit point.
  logic       rs_s1, rs_s2, rw_s1, rw_s2, e_s1, e_s2;
  logic [7:0] db_s1, db_s2;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      rs_s1 <= 1'b0; rs_s2 <= 1'b0;
      rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      e_s1  <= 1'b0; e_s2  <= 1'b0;
      db_s1 <= 8'h00; db_s2 <= 8'h00;
    end else begin
      rs_s1 <= rs_pin; rs_s2 <= rs_s1;
      rw_s1 <= rw_pin; rw_s2 <= rw_s1;
      e_s1  <= e_pin;  e_s2  <= e_s1;
      db_s1 <= db_in;  db_s2 <= db_s1;
    end
  end

  logic e_fall, wr_fall, rd_fall, accept;
  assign e_fall  = e_s2 & ~e_s1;
  assign wr_fall = e_fall & ~rw_s2;
  assign rd_fall = e_fall & rw_s2;
  assign db_oe   = rw_s2 & e_s2;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
  logic [ADDR_W-1:0] ac;
  logic              inc_dir;
  logic              cmd_rs;
  logic [7:0]        cmd_db;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata, bus_rdata;

  assign accept = wr_fall & (state == ST_IDLE);
  // The flag drops on the final count cycle, while the FSM still refuses writes then.
  assign busy   = (state != ST_IDLE) && !((state == ST_BUSY) && (cnt == '0));

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    clr_idx_nxt = clr_idx;
    ram_we      = 1'b0;
    ram_waddr   = ac;
    ram_wdata   = cmd_db;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (!cmd_rs && (cmd_db == OP_CLEAR)) begin
          state_nxt   = ST_CLEAR;
          clr_idx_nxt = '0;
        end else begin
          state_nxt = ST_BUSY;
          cnt_nxt   = CNT_W'(BUSY_CYCLES);
          ram_we    = cmd_rs;
        end
      end
      ST_CLEAR: begin
        ram_we      = 1'b1;
        ram_waddr   = clr_idx;
        ram_wdata   = CHAR_SPACE;
        clr_idx_nxt = clr_idx + ADDR_W'(1);
        if (clr_idx == LAST_ADDR) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = CNT_W'(CLEAR_CYCLES);
        end
      end
      ST_BUSY: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else cnt_nxt = cnt - CNT_W'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic is_set_ddram, is_ignored, is_disp_ctrl, is_entry, is_home;
  assign is_set_ddram = |(cmd_db & OP_SET_DDRAM);
  assign is_ignored   = |(cmd_db & (OP_SET_CGRAM | OP_FUNC_SET | OP_SHIFT));
  assign is_disp_ctrl = |(cmd_db & OP_DISP_CTRL);
  assign is_entry     = |(cmd_db & OP_ENTRY);
  assign is_home      = |(cmd_db & OP_HOME);

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      ac         <= '0;
      inc_dir    <= 1'b1;
      display_on <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_word   <= 9'h000;
      proto_err  <= 1'b0;
      cmd_rs     <= 1'b0;
      cmd_db     <= 8'h00;
      db_out     <= 8'h00;
    end else begin
      cmd_valid <= accept;
      proto_err <= wr_fall & (state != ST_IDLE);
      db_out    <= rs_s2 ? bus_rdata : status_byte(busy, ac);
      if (accept) begin
        cmd_rs   <= rs_s2;
        cmd_db   <= db_s2;
        cmd_word <= {rs_s2, db_s2};
      end
      if (state == ST_EXEC) begin
        if (cmd_rs) ac <= ac_step(ac, inc_dir);
        else if (is_set_ddram) ac <= {cmd_db[6], cmd_db[3:0]};
        else if (!is_ignored) begin
          if (is_disp_ctrl) display_on <= cmd_db[2];
          else if (is_entry) inc_dir <= cmd_db[1];
          else if (is_home) ac <= '0;
        end
      end else if ((state == ST_CLEAR) && (clr_idx == LAST_ADDR)) begin
        ac      <= '0;
        inc_dir <= 1'b1;
      end else if (rd_fall && rs_s2 && (state != ST_CLEAR)) begin
        ac <= ac_step(ac, inc_dir);
      end
    end
  end

  ddram_2x16 u_ddram (
    .clk_48mhz (clk_48mhz),
    .we        (ram_we),
    .waddr     (ram_waddr),
    .wdata     (ram_wdata),
    .raddr_a   (ac),
    .rdata_a   (bus_rdata),
    .raddr_b   (view_addr),
    .rdata_b   (view_data)
  );

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder: drives the parallel bus like the OLED master
// and checks accepted/rejected writes, status and data reads and the DDRAM view port.
module tb_hd44780_responder;

  logic       clk_48mhz = 1'b0;
  logic       reset = 1'b1;
  logic       rs_pin = 1'b0, rw_pin = 1'b0, e_pin = 1'b0;
  logic [7:0] db_in = 8'h00;
  logic [4:0] view_addr = 5'd0;
  logic [7:0] db_out, view_data;
  logic       db_oe, busy, display_on, cmd_valid, proto_err;
  logic [8:0] cmd_word;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  hd44780_responder dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .rs_pin     (rs_pin),
    .rw_pin     (rw_pin),
    .e_pin      (e_pin),
    .db_in      (db_in),
    .db_out     (db_out),
    .db_oe      (db_oe),
    .busy       (busy),
    .display_on (display_on),
    .cmd_valid  (cmd_valid),
    .cmd_word   (cmd_word),
    .proto_err  (proto_err),
    .view_addr  (view_addr),
    .view_data  (view_data)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: {1, 9'h0} marks an expected proto_err, {0, rs, db} a cmd_valid.
  always @(negedge clk_48mhz) begin
    logic [9:0] got, want;
    if (!reset && (cmd_valid || proto_err)) begin
      got = proto_err ? 10'h200 : {1'b0, cmd_word};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual=%h required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL cmd_event actual=%h required=%h", got, want);
        end
      end
    end
  end

  task automatic bus_write(input logic rs, input logic [7:0] d, input logic acc);
    exp_q.push_back(acc ? {1'b0, rs, d} : 10'h200);
    @(negedge clk_48mhz);
    rs_pin = rs; rw_pin = 1'b0; db_in = d;
    @(negedge clk_48mhz);
    e_pin = 1'b1;
    repeat (6) @(negedge clk_48mhz);
    e_pin = 1'b0;
    repeat (4) @(negedge clk_48mhz);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] d);
    @(negedge clk_48mhz);
    rs_pin = rs; rw_pin = 1'b1;
    @(negedge clk_48mhz);
    e_pin = 1'b1;
    repeat (8) @(negedge clk_48mhz);
    d = db_out;
    e_pin = 1'b0;
    repeat (4) @(negedge clk_48mhz);
    rw_pin = 1'b0;
  endtask

  task automatic wait_idle();
    logic [7:0] s;
    int n;
    n = 0;
    do begin
      bus_read(1'b0, s);
      n++;
    end while (s[7] && n < 1000);
    if (s[7]) begin
      checks++;
      failures++;
      $display("FAIL wait_idle actual=%h required=busy_clear", s);
    end
  endtask

  task automatic status_check(input string name, input logic [7:0] exp);
    logic [7:0] s;
    wait_idle();
    bus_read(1'b0, s);
    check(name, {8'h00, s}, {8'h00, exp});
  endtask

  task automatic view_check(input string name, input logic [4:0] a, input logic [7:0] exp);
    @(negedge clk_48mhz);
    view_addr = a;
    @(negedge clk_48mhz);
    check(name, {8'h00, view_data}, {8'h00, exp});
  endtask

  task automatic idle_write(input logic rs, input logic [7:0] d);
    wait_idle();
    bus_write(rs, d, 1'b1);
  endtask

  initial begin
    string text;
    logic [7:0] rd;
    int n;
    text = "TinyFPGA-BX";

    repeat (4) @(negedge clk_48mhz);
    check("rst_db_out", {8'h00, db_out}, 16'h0000);
    check("rst_db_oe", {15'h0, db_oe}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    check("rst_display_on", {15'h0, display_on}, 16'h0000);
    check("rst_cmd_valid", {15'h0, cmd_valid}, 16'h0000);
    check("rst_cmd_word", {7'h0, cmd_word}, 16'h0000);
    check("rst_proto_err", {15'h0, proto_err}, 16'h0000);
    reset = 1'b0;
    repeat (2) @(negedge clk_48mhz);
    status_check("rst_status", 8'h00);

    // 1: init sequence with busy polling, display cleared to spaces
    idle_write(1'b0, 8'h38);
    idle_write(1'b0, 8'h0C);
    idle_write(1'b0, 8'h01);
    idle_write(1'b0, 8'h06);
    wait_idle();
    check("init_display_on", {15'h0, display_on}, 16'h0001);
    for (int i = 0; i < 32; i++) view_check("init_space", 5'(i), 8'h20);

    // 2: text on line 0
    idle_write(1'b0, 8'h80);
    for (int i = 0; i < text.len(); i++) idle_write(1'b1, text[i]);
    wait_idle();
    for (int i = 0; i < text.len(); i++) view_check("text_view", 5'(i), text[i]);
    status_check("text_status", 8'h0B);

    // 3: wrap from line1 col15 back to line0 col0
    idle_write(1'b0, 8'hCF);
    idle_write(1'b1, "A");
    idle_write(1'b1, "B");
    wait_idle();
    view_check("wrap_view31", 5'd31, "A");
    view_check("wrap_view0", 5'd0, "B");
    status_check("wrap_status", 8'h01);

    // 4: decrement mode wraps line0 col0 to line1 col15
    idle_write(1'b0, 8'h04);
    idle_write(1'b0, 8'h80);
    idle_write(1'b1, "Z");
    wait_idle();
    view_check("dec_view0", 5'd0, "Z");
    status_check("dec_status", 8'h4F);
    idle_write(1'b0, 8'h06);

    // 5: second write inside the busy window is dropped
    idle_write(1'b0, 8'h85);
    idle_write(1'b1, "Q");
    bus_write(1'b1, "R", 1'b0);
    wait_idle();
    view_check("drop_view5", 5'd5, "Q");
    view_check("drop_view6", 5'd6, "G");
    status_check("drop_status", 8'h06);
    idle_write(1'b0, 8'h80);
    wait_idle();
    bus_read(1'b1, rd);
    check("data_read", {8'h00, rd}, {8'h00, "Z"});
    status_check("data_read_ac", 8'h01);

    // 6: reset ten cycles into a clear
    wait_idle();
    exp_q.push_back(10'h001);
    @(negedge clk_48mhz);
    rs_pin = 1'b0; rw_pin = 1'b0; db_in = 8'h01;
    @(negedge clk_48mhz);
    e_pin = 1'b1;
    repeat (6) @(negedge clk_48mhz);
    e_pin = 1'b0;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk_48mhz);
      n++;
    end
    check("clear_busy_rise", {15'h0, busy}, 16'h0001);
    repeat (10) @(negedge clk_48mhz);
    reset = 1'b1;
    @(negedge clk_48mhz);
    check("midclear_busy", {15'h0, busy}, 16'h0000);
    reset = 1'b0;
    repeat (2) @(negedge clk_48mhz);
    check("midclear_display_on", {15'h0, display_on}, 16'h0000);
    status_check("midclear_status", 8'h00);
    view_check("midclear_view0", 5'd0, 8'h20);
    view_check("midclear_view10", 5'd10, "X");
    for (int i = 11; i < 31; i++) view_check("midclear_view", 5'(i), 8'h20);
    view_check("midclear_view31", 5'd31, "A");

    repeat (4) @(negedge clk_48mhz);
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
